// File: rtl/image_conv_ctrl_if.sv
// Pixel stream and datapath bundle for the convolution controller: upstream
// raster stream, downstream result stream and the window datapath hooks.
interface image_conv_ctrl_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic                   in_valid;
    logic [PIXEL_WIDTH-1:0] in_pixel;
    logic                   in_ready;

    logic                   out_valid;
    logic [PIXEL_WIDTH-1:0] out_pixel;
    logic                   out_last;
    logic                   out_ready;

    logic                   conv_en;
    logic [PIXEL_WIDTH-1:0] conv_pixel;
    logic [1:0]             conv_mode;
    logic [PIXEL_WIDTH-1:0] conv_result;

    // Environment side: pixel source, result sink and the window datapath.
    modport master (
        output in_valid, in_pixel, out_ready, conv_result,
        input  in_ready, out_valid, out_pixel, out_last,
        input  conv_en, conv_pixel, conv_mode
    );

    // Controller side.
    modport slave (
        input  in_valid, in_pixel, out_ready, conv_result,
        output in_ready, out_valid, out_pixel, out_last,
        output conv_en, conv_pixel, conv_mode
    );
endinterface

// File: rtl/image_conv_ctrl.sv
// Frame sequencer for a 3x3 sliding-window convolution: counts raster pixels,
// steps the window datapath and emits one result per fully covered window.
module image_conv_ctrl #(
    parameter int PIXEL_WIDTH = 8,
    parameter int DIM_W       = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic [1:0]       cfg_mode,
    image_conv_ctrl_if.slave px,
    output logic             busy,
    output logic             done,
    output logic             err_cfg
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] width_q, width_d;
    logic [DIM_W-1:0] height_q, height_d;
    logic [DIM_W-1:0] row_q, row_d;
    logic [DIM_W-1:0] col_q, col_d;
    logic [1:0]       mode_q, mode_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             done_q, done_d;
    logic             err_cfg_q, err_cfg_d;

    logic             cfg_ok;
    logic             xfer;
    logic             end_of_row;
    logic             final_px;
    logic             producing;
    logic             out_hs;
    logic [PIXEL_WIDTH-1:0] result_w;

    assign cfg_ok     = (cfg_width >= DIM_W'(3)) && (cfg_height >= DIM_W'(3));
    assign end_of_row = (col_q == width_q - DIM_W'(1));
    assign final_px   = end_of_row && (row_q == height_q - DIM_W'(1));
    assign producing  = xfer && (row_q >= DIM_W'(2)) && (col_q >= DIM_W'(2));
    assign out_hs     = out_valid_q && px.out_ready;

    // Status and handshake outputs are forced low for as long as rst is held.
    assign px.in_ready = !rst && (state_q == RUN) && (!out_valid_q || px.out_ready);
    assign xfer        = px.in_valid && px.in_ready;

    assign px.conv_en    = xfer;
    assign px.conv_pixel = px.in_pixel;
    assign px.conv_mode  = mode_q;

    // The datapath result is registered and frozen while conv_en is low, so
    // it can be forwarded directly and stays stable through a stall.
    assign result_w     = px.conv_result;
    assign px.out_pixel = result_w;
    assign px.out_valid = out_valid_q && !rst;
    assign px.out_last  = out_last_q && !rst;
    assign busy         = (state_q != IDLE) && !rst;
    assign done         = done_q && !rst;
    assign err_cfg      = err_cfg_q && !rst;

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        mode_d      = mode_q;
        row_d       = row_q;
        col_d       = col_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        err_cfg_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        width_d  = cfg_width;
                        height_d = cfg_height;
                        mode_d   = cfg_mode;
                        row_d    = '0;
                        col_d    = '0;
                        state_d  = RUN;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            RUN:     if (xfer && final_px) state_d = DRAIN;
            DRAIN: begin
                if (out_hs && out_last_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (xfer) begin
            if (end_of_row) begin
                col_d = '0;
                row_d = row_q + DIM_W'(1);
            end else begin
                col_d = col_q + DIM_W'(1);
            end
        end

        // A new result replaces the one being accepted in the same cycle.
        if (producing) begin
            out_valid_d = 1'b1;
            out_last_d  = final_px;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            row_d       = '0;
            col_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            mode_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_cfg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            mode_q      <= mode_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            err_cfg_q   <= err_cfg_d;
        end
    end
endmodule
